// File: rtl/gs_frame_ctrl.sv
// ---------------------------------------------------------------------------
// gs_frame_ctrl
//   Frame sequencer around the 3x3 Gaussian filter stage.
//
//   Input side : accepts a ready/valid pixel stream, checks the frame
//                geometry against IMG_W x IMG_H and forwards beats to the
//                filter (f_din*), flagging frame_done / err_pulse.
//   Output side: tracks the row/column of every filter result and forwards
//                only pixels whose 3x3 window is fully inside the frame,
//                re-framed with cropped sop/eop (m_*).
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   en                               enable; s_ready = en
//   s_data/s_valid/s_sop/s_eop       source stream in
//   s_ready                          source accept
//   f_din/f_din_vld/_sop/_eop        registered stream to the filter
//   f_dout/f_dout_vld/_sop/_eop      filter results
//   m_data/m_vld/m_sop/m_eop         full-window pixels to the Sobel stage
//   frame_done                       pulse: frame accepted, geometry correct
//   err_pulse                        pulse: framing error
// ---------------------------------------------------------------------------
module gs_frame_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  input  logic          s_sop,
  input  logic          s_eop,
  output logic          s_ready,
  output logic [DW-1:0] f_din,
  output logic          f_din_vld,
  output logic          f_din_sop,
  output logic          f_din_eop,
  input  logic [DW-1:0] f_dout,
  input  logic          f_dout_vld,
  input  logic          f_dout_sop,
  input  logic          f_dout_eop,
  output logic [DW-1:0] m_data,
  output logic          m_vld,
  output logic          m_sop,
  output logic          m_eop,
  output logic          frame_done,
  output logic          err_pulse
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;

  logic accept;
  logic fwd;
  logic at_last;

  assign s_ready = en;
  assign accept  = s_valid & en;
  // In IDLE only a sop beat starts a frame; everything else is dropped.
  assign fwd     = accept & ((state == RUN) | s_sop);
  assign at_last = (in_row == ROW_LAST) && (in_col == COL_LAST);

  // -------------------------------------------------------------------------
  // Input sequencer. in_col/in_row hold the position of the next beat.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_col     <= '0;
      in_row     <= '0;
      f_din      <= '0;
      f_din_vld  <= 1'b0;
      f_din_sop  <= 1'b0;
      f_din_eop  <= 1'b0;
      frame_done <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      f_din_vld  <= 1'b0;
      f_din_sop  <= 1'b0;
      f_din_eop  <= 1'b0;
      frame_done <= 1'b0;
      err_pulse  <= 1'b0;

      if (fwd) begin
        f_din     <= s_data;
        f_din_vld <= 1'b1;
        f_din_sop <= s_sop;
        f_din_eop <= s_eop;
      end

      if (accept) begin
        unique case (state)
          IDLE: begin
            if (s_sop) begin
              in_col <= CW'(1);
              in_row <= '0;
              state  <= RUN;
            end
          end
          RUN: begin
            if (s_sop) begin
              // Mid-frame sop restarts the frame at this beat; eop ignored.
              err_pulse <= 1'b1;
              in_col    <= CW'(1);
              in_row    <= '0;
            end else if (s_eop || at_last) begin
              // Frame ends here either way; only eop exactly at the last
              // position counts as a good frame.
              if (s_eop && at_last) begin
                frame_done <= 1'b1;
              end else begin
                err_pulse <= 1'b1;
              end
              in_col <= '0;
              in_row <= '0;
              state  <= IDLE;
            end else if (in_col == COL_LAST) begin
              in_col <= '0;
              in_row <= in_row + RW'(1);
            end else begin
              in_col <= in_col + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output tracker. The filter has no stall, so this side is not gated by en;
  // holding it would drop results already in flight.
  // nxt_col/nxt_row hold the position of the next result beat.
  // -------------------------------------------------------------------------
  logic          out_sync;
  logic [CW-1:0] nxt_col;
  logic [RW-1:0] nxt_row;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          beat_ok;
  logic          full_win;
  logic          dout_eop_unused;

  // Result framing is derived from position alone; the filter's eop is
  // redundant with the counters.
  assign dout_eop_unused = f_dout_eop;

  always_comb begin
    cur_col  = nxt_col;
    cur_row  = nxt_row;
    if (f_dout_sop) begin
      cur_col = '0;
      cur_row = '0;
    end
    beat_ok  = f_dout_vld & (f_dout_sop | out_sync);
    full_win = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sync <= 1'b0;
      nxt_col  <= '0;
      nxt_row  <= '0;
      m_data   <= '0;
      m_vld    <= 1'b0;
      m_sop    <= 1'b0;
      m_eop    <= 1'b0;
    end else begin
      m_vld <= 1'b0;
      m_sop <= 1'b0;
      m_eop <= 1'b0;

      if (beat_ok) begin
        out_sync <= 1'b1;
        if (cur_col == COL_LAST) begin
          nxt_col <= '0;
          nxt_row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          nxt_col <= cur_col + CW'(1);
          nxt_row <= cur_row;
        end

        if (full_win) begin
          m_vld  <= 1'b1;
          m_data <= f_dout;
          m_sop  <= (cur_row == RW'(2)) && (cur_col == CW'(2));
          m_eop  <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end
      end
    end
  end

endmodule

// File: tb/tb_gs_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gs_frame_ctrl
//   Directed bench for gs_frame_ctrl at IMG_W=8, IMG_H=6. The filter stage is
//   stood in by a 4-cycle identity delay. A reference model working on linear
//   pixel indices predicts every registered output each cycle; per-test
//   totals are pinned with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_gs_frame_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;
  localparam int unsigned N  = W * H;
  localparam int          DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_sop = 1'b0;
  logic          s_eop = 1'b0;
  logic          s_ready;
  logic [DW-1:0] f_din;
  logic          f_din_vld, f_din_sop, f_din_eop;
  logic [DW-1:0] f_dout;
  logic          f_dout_vld, f_dout_sop, f_dout_eop;
  logic [DW-1:0] m_data;
  logic          m_vld, m_sop, m_eop;
  logic          frame_done, err_pulse;

  always #5 clk = ~clk;

  gs_frame_ctrl #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop),
    .s_ready(s_ready),
    .f_din(f_din), .f_din_vld(f_din_vld), .f_din_sop(f_din_sop), .f_din_eop(f_din_eop),
    .f_dout(f_dout), .f_dout_vld(f_dout_vld), .f_dout_sop(f_dout_sop), .f_dout_eop(f_dout_eop),
    .m_data(m_data), .m_vld(m_vld), .m_sop(m_sop), .m_eop(m_eop),
    .frame_done(frame_done), .err_pulse(err_pulse)
  );

  // Filter stand-in: 4-cycle delay of {vld, sop, eop, data}.
  logic [DW+2:0] fpipe [4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) fpipe[i] <= '0;
    end else begin
      fpipe[0] <= {f_din_vld, f_din_sop, f_din_eop, f_din};
      for (int i = 1; i < 4; i++) fpipe[i] <= fpipe[i-1];
    end
  end
  assign {f_dout_vld, f_dout_sop, f_dout_eop, f_dout} = fpipe[3];

  // Reference model on linear indices.
  bit            in_act, out_act;
  int unsigned   in_idx, out_idx;
  logic          e_fvld, e_fsop, e_feop, e_done, e_err, e_mvld, e_msop, e_meop;
  logic [DW-1:0] e_fdin, e_mdata;

  always @(posedge clk or negedge rst_n) begin : model
    int unsigned p;
    if (!rst_n) begin
      in_act <= 1'b0; out_act <= 1'b0; in_idx <= 0; out_idx <= 0;
      e_fvld <= 1'b0; e_fsop <= 1'b0; e_feop <= 1'b0; e_done <= 1'b0; e_err <= 1'b0;
      e_mvld <= 1'b0; e_msop <= 1'b0; e_meop <= 1'b0; e_fdin <= '0; e_mdata <= '0;
    end else begin
      e_fvld <= 1'b0; e_fsop <= 1'b0; e_feop <= 1'b0; e_done <= 1'b0; e_err <= 1'b0;
      e_mvld <= 1'b0; e_msop <= 1'b0; e_meop <= 1'b0;
      if (s_valid && en) begin
        if (in_act || s_sop) begin
          e_fvld <= 1'b1; e_fdin <= s_data; e_fsop <= s_sop; e_feop <= s_eop;
        end
        if (!in_act) begin
          if (s_sop) begin in_act <= 1'b1; in_idx <= 1; end
        end else if (s_sop) begin
          e_err <= 1'b1; in_idx <= 1;
        end else if (s_eop || in_idx == N - 1) begin
          in_act <= 1'b0;
          if (s_eop && in_idx == N - 1) e_done <= 1'b1;
          else e_err <= 1'b1;
        end else begin
          in_idx <= in_idx + 1;
        end
      end
      if (f_dout_vld && (f_dout_sop || out_act)) begin
        p = f_dout_sop ? 0 : out_idx;
        out_act <= 1'b1;
        out_idx <= (p + 1) % N;
        if (p / W >= 2 && p % W >= 2) begin
          e_mvld  <= 1'b1;
          e_mdata <= f_dout;
          e_msop  <= (p == 2 * W + 2);
          e_meop  <= (p == N - 1);
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("s_ready", s_ready, en);
    check("f_din_vld", f_din_vld, e_fvld);
    check("f_din", f_din, e_fdin);
    check("f_din_sop", f_din_sop, e_fsop);
    check("f_din_eop", f_din_eop, e_feop);
    check("frame_done", frame_done, e_done);
    check("err_pulse", err_pulse, e_err);
    check("m_vld", m_vld, e_mvld);
    check("m_data", m_data, e_mdata);
    check("m_sop", m_sop, e_msop);
    check("m_eop", m_eop, e_meop);
  end

  // Running event totals taken from the DUT outputs.
  int c_fvld = 0, c_done = 0, c_err = 0, c_mvld = 0, c_msop = 0, c_meop = 0, c_not100 = 0;
  logic [DW-1:0] sop_data = '0, eop_data = '0, done_din = '0;
  always @(negedge clk) begin
    if (f_din_vld) c_fvld <= c_fvld + 1;
    if (frame_done) begin c_done <= c_done + 1; done_din <= f_din; end
    if (err_pulse) c_err <= c_err + 1;
    if (m_vld) begin
      c_mvld <= c_mvld + 1;
      if (m_data != 8'd100) c_not100 <= c_not100 + 1;
      if (m_sop) begin c_msop <= c_msop + 1; sop_data <= m_data; end
      if (m_eop) begin c_meop <= c_meop + 1; eop_data <= m_data; end
    end
  end

  int b_fvld, b_done, b_err, b_mvld, b_msop, b_meop, b_not100;
  task automatic snap();
    b_fvld = c_fvld; b_done = c_done; b_err = c_err; b_mvld = c_mvld;
    b_msop = c_msop; b_meop = c_meop; b_not100 = c_not100;
  endtask

  task automatic expect_counts(input string tag, input int fvld, input int done,
                               input int err, input int mvld);
    check({tag, "_fvld"}, c_fvld - b_fvld, fvld);
    check({tag, "_done"}, c_done - b_done, done);
    check({tag, "_err"},  c_err - b_err, err);
    check({tag, "_mvld"}, c_mvld - b_mvld, mvld);
  endtask

  // All stimulus tasks start and end at posedge + 2.
  task automatic send(input logic [DW-1:0] d, input logic sop, input logic eop);
    int unsigned n;
    n = 0;
    s_data = d; s_sop = sop; s_eop = eop; s_valid = 1'b1;
    do begin
      @(posedge clk);
      n++;
    end while (!en && n < 50);
    if (!en) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: beat not accepted within %0d cycles", n);
    end
    #2;
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // cval < 0: pixel value = index, otherwise constant cval.
  task automatic clean_frame(input int cval);
    for (int i = 0; i < int'(N); i++)
      send((cval < 0) ? DW'(i) : DW'(cval), i == 0, i == int'(N) - 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {f_din_vld, f_din_sop, f_din_eop, frame_done, err_pulse,
                m_vld, m_sop, m_eop, f_din, m_data}, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    en = 1'b1;
    #3;
    check_reset_outputs("reset_outputs");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // T1: clean frame, data = index.
    snap();
    clean_frame(-1);
    idle(10);
    expect_counts("t1", 48, 1, 0, 24);
    check("t1_msop_cnt", c_msop - b_msop, 1);
    check("t1_meop_cnt", c_meop - b_meop, 1);
    check("t1_sop_data", sop_data, 18);
    check("t1_eop_data", eop_data, 47);
    check("t1_done_beat", done_din, 47);

    // T2: constant 100.
    snap();
    clean_frame(100);
    idle(10);
    expect_counts("t2", 48, 1, 0, 24);
    check("t2_not100", c_not100 - b_not100, 0);

    // T3: eop on beat 30, then 5 stray beats, then a clean frame.
    snap();
    for (int i = 0; i <= 30; i++) send(DW'(i), i == 0, i == 30);
    idle(10);
    expect_counts("t3a", 31, 0, 1, 11);
    for (int i = 0; i < 5; i++) send(DW'(200 + i), 1'b0, 1'b0);
    idle(10);
    check("t3_discard_fvld", c_fvld - b_fvld, 31);
    snap();
    clean_frame(-1);
    idle(10);
    expect_counts("t3b", 48, 1, 0, 24);

    // T4: sop reasserted on beat 20.
    snap();
    for (int i = 0; i < 20; i++) send(DW'(i), i == 0, 1'b0);
    clean_frame(-1);
    idle(10);
    expect_counts("t4", 68, 1, 1, 26);
    check("t4_msop_cnt", c_msop - b_msop, 2);
    check("t4_meop_cnt", c_meop - b_meop, 1);
    check("t4_done_beat", done_din, 47);

    // T5: last beat without eop, then one beat without sop.
    snap();
    for (int i = 0; i < int'(N); i++) send(DW'(i), i == 0, 1'b0);
    idle(10);
    expect_counts("t5a", 48, 0, 1, 24);
    check("t5_meop_cnt", c_meop - b_meop, 1);
    snap();
    send(8'd77, 1'b0, 1'b0);
    idle(10);
    expect_counts("t5b", 0, 0, 0, 0);

    // T6: en low for 3 cycles every 7 beats, s_valid held.
    snap();
    for (int i = 0; i < int'(N); i++) begin
      if (i % 7 == 0 && i != 0) begin
        en = 1'b0;
        fork
          begin
            repeat (3) @(posedge clk);
            #2 en = 1'b1;
          end
        join_none
      end
      send(DW'(i), i == 0, i == int'(N) - 1);
    end
    idle(10);
    expect_counts("t6", 48, 1, 0, 24);
    check("t6_sop_data", sop_data, 18);
    check("t6_eop_data", eop_data, 47);

    // T7: reset mid-frame after beat 24.
    for (int i = 0; i < 25; i++) send(DW'(i), i == 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t7_reset_outputs");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    snap();
    clean_frame(-1);
    idle(10);
    expect_counts("t7", 48, 1, 0, 24);
    check("t7_done_beat", done_din, 47);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
